// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the morse symbol interface.
// Symbol encoding matches the parser's DATA_OUT, so parser output can be
// looped straight back into the keyer. Also holds the keyer state type,
// segment unit counts and helpers mapping a symbol to its first segment.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_GAP  = 2'b00,
    SYM_DOT  = 2'b01,
    SYM_DASH = 2'b10,
    SYM_WORD = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam logic [2:0] DOT_UNITS          = 3'd1;
  localparam logic [2:0] DASH_UNITS         = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS     = 3'd1;
  // Gap symbols only add to the 1-unit inter-element space already played
  // after a mark: 1 + 2 = 3 units between letters, 1 + 6 = 7 between words.
  localparam logic [2:0] LETTER_EXTRA_UNITS = 3'd2;
  localparam logic [2:0] WORD_EXTRA_UNITS   = 3'd6;

  function automatic state_t seg_state(input sym_t s);
    return (s == SYM_DOT || s == SYM_DASH) ? MARK : SPACE;
  endfunction

  function automatic logic [2:0] seg_units(input sym_t s);
    case (s)
      SYM_DOT:  return DOT_UNITS;
      SYM_DASH: return DASH_UNITS;
      SYM_GAP:  return LETTER_EXTRA_UNITS;
      default:  return WORD_EXTRA_UNITS;
    endcase
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: synchronous FIFO with occupancy count.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata write request/data; ignored while full
//   pop         read request; ignored while empty
//   rdata       head entry (valid while !empty)
//   full, empty status flags
//   level       occupancy, 0..DEPTH
module sym_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: plays buffered morse symbols as a timed on/off key signal.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   EN          playback enable; low freezes timing and forces KEY_OUT low
//   SYM_VALID   symbol offered
//   SYM_DATA    symbol (sym_t encoding)
//   SYM_READY   FIFO can accept (= !full)
//   KEY_OUT     registered key, 1 = mark
//   BUSY        playing a segment or symbols still buffered
//   FIFO_LEVEL  FIFO occupancy
//   DBG_STATE   current FSM state, for observation
// Handshake: a symbol transfers on a rising CLK edge where SYM_VALID and
// SYM_READY are both high. SYM_READY depends only on FIFO fullness, never on
// a pop in the same cycle; the source must hold data until accepted.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int DEPTH       = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  input  logic                     SYM_VALID,
  input  logic [1:0]               SYM_DATA,
  output logic                     SYM_READY,
  output logic                     KEY_OUT,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output state_t                   DBG_STATE
);

  localparam int PW = $clog2(UNIT_CYCLES);

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    units_q, units_d;
  logic          key_q;
  logic          pop;
  logic          full;
  logic          empty;
  logic [1:0]    head;
  logic          tick;
  logic          last;

  sym_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (SYM_VALID),
    .wdata (SYM_DATA),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (FIFO_LEVEL)
  );

  assign SYM_READY = !full;
  assign BUSY      = (state_q != IDLE) || !empty;
  assign KEY_OUT   = key_q;
  assign DBG_STATE = state_q;

  // tick marks the terminal prescaler count; last is the final cycle of
  // the current segment, where the next segment may be loaded directly.
  assign tick = (pre_q == PW'(UNIT_CYCLES - 1));
  assign last = tick && (units_q == 3'd1);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    units_d = units_q;
    pop     = 1'b0;
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = seg_state(sym_t'(head));
            units_d = seg_units(sym_t'(head));
            pre_d   = '0;
          end
        end
        MARK: begin
          if (last) begin
            state_d = SPACE;
            units_d = ELEM_GAP_UNITS;
            pre_d   = '0;
          end else if (tick) begin
            units_d = units_q - 3'd1;
            pre_d   = '0;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        SPACE: begin
          if (last) begin
            pre_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = seg_state(sym_t'(head));
              units_d = seg_units(sym_t'(head));
            end else begin
              state_d = IDLE;
              units_d = '0;
            end
          end else if (tick) begin
            units_d = units_q - 3'd1;
            pre_d   = '0;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          units_d = '0;
          pre_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pre_q   <= '0;
      units_q <= '0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      units_q <= units_d;
      // Key follows the segment being entered, so it lines up with the
      // state register one cycle after the pop.
      key_q   <= EN && (state_d == MARK);
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: directed bench for morse_keyer at UNIT_CYCLES=4, DEPTH=8.
module tb_morse_keyer;
  import morse_pkg::*;

  localparam int UNIT  = 4;
  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic       SYM_VALID = 1'b0;
  logic [1:0] SYM_DATA = 2'b00;
  logic       SYM_READY;
  logic       KEY_OUT;
  logic       BUSY;
  logic [3:0] FIFO_LEVEL;
  state_t     DBG_STATE;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  morse_keyer #(.UNIT_CYCLES(UNIT), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .SYM_VALID  (SYM_VALID),
    .SYM_DATA   (SYM_DATA),
    .SYM_READY  (SYM_READY),
    .KEY_OUT    (KEY_OUT),
    .BUSY       (BUSY),
    .FIFO_LEVEL (FIFO_LEVEL),
    .DBG_STATE  (DBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input logic [1:0] s);
    SYM_DATA  = s;
    SYM_VALID = 1'b1;
    tick();
    SYM_VALID = 1'b0;
  endtask

  // Length of the run of KEY_OUT==lvl while BUSY, bounded.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (KEY_OUT === lvl && BUSY && n < 300) begin
      n++;
      tick();
    end
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int hi;
    int pause_hi;
    int guard;
    int busy_cnt;

    // Reset
    repeat (2) tick();
    chk("rst_key", KEY_OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", SYM_READY, 1);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_state", int'(DBG_STATE), int'(IDLE));
    RST_N = 1'b1;
    tick();

    // 1: single dot, EN=1
    EN = 1'b1;
    push_one(SYM_DOT);
    chk("dot_level_after_push", FIFO_LEVEL, 1);
    chk("dot_key_before_pop", KEY_OUT, 0);
    tick();
    chk("dot_level_after_pop", FIFO_LEVEL, 0);
    chk("dot_state_mark", int'(DBG_STATE), int'(MARK));
    run_len(1'b1, n);
    chk("dot_mark_len", n, 4);
    run_len(1'b0, n);
    chk("dot_space_len", n, 4);
    chk("dot_busy_end", BUSY, 0);
    chk("dot_state_end", int'(DBG_STATE), int'(IDLE));

    // 2: dash, letter gap, dot played back-to-back
    EN = 1'b0;
    push_one(SYM_DASH);
    push_one(SYM_GAP);
    push_one(SYM_DOT);
    chk("seq_level", FIFO_LEVEL, 3);
    exp_q.push_back(8'd12);
    exp_q.push_back(8'd12);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd4);
    EN = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      run_len((i % 2 == 0) ? 1'b1 : 1'b0, n);
      chk($sformatf("seq_run%0d", i), n, int'(e));
    end
    chk("seq_busy_end", BUSY, 0);

    // 3: fill FIFO with EN low, then play out
    EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill_ready%0d", i), SYM_READY, 1);
      push_one(SYM_DOT);
    end
    chk("fill_level_full", FIFO_LEVEL, 8);
    chk("fill_ready_full", SYM_READY, 0);
    SYM_DATA  = SYM_DOT;
    SYM_VALID = 1'b1;
    repeat (3) tick();
    chk("fill_level_held", FIFO_LEVEL, 8);
    chk("fill_key_paused", KEY_OUT, 0);
    EN = 1'b1;
    tick();
    chk("fill_level_pop_no_push", FIFO_LEVEL, 7);
    chk("fill_ready_after_pop", SYM_READY, 1);
    hi = KEY_OUT;
    tick();
    chk("fill_level_ninth_accepted", FIFO_LEVEL, 8);
    SYM_VALID = 1'b0;
    hi += KEY_OUT;
    guard = 0;
    while (BUSY && guard < 1000) begin
      tick();
      guard++;
      hi += KEY_OUT;
    end
    chk("fill_drain_done", BUSY, 0);
    chk("fill_mark_cycles", hi, 36);

    // 4: pause in the middle of a dash
    push_one(SYM_DASH);
    tick();
    hi = 0;
    repeat (5) begin
      hi += KEY_OUT;
      tick();
    end
    EN = 1'b0;
    hi += KEY_OUT;
    pause_hi = 0;
    repeat (10) begin
      tick();
      pause_hi += KEY_OUT;
    end
    chk("pause_key_low", pause_hi, 0);
    chk("pause_state_frozen", int'(DBG_STATE), int'(MARK));
    EN = 1'b1;
    guard = 0;
    while (BUSY && guard < 200) begin
      tick();
      guard++;
      hi += KEY_OUT;
    end
    chk("pause_total_mark", hi, 12);
    chk("pause_busy_end", BUSY, 0);

    // 5: word gap alone
    push_one(SYM_WORD);
    chk("word_level", FIFO_LEVEL, 1);
    tick();
    chk("word_state_space", int'(DBG_STATE), int'(SPACE));
    run_len(1'b0, n);
    chk("word_space_len", n, 24);
    chk("word_busy_end", BUSY, 0);

    // 6: reset mid-dash with symbols queued
    EN = 1'b0;
    push_one(SYM_DASH);
    push_one(SYM_DOT);
    push_one(SYM_DOT);
    push_one(SYM_DOT);
    EN = 1'b1;
    repeat (3) tick();
    chk("rstmid_key_before", KEY_OUT, 1);
    chk("rstmid_level_before", FIFO_LEVEL, 3);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rstmid_key", KEY_OUT, 0);
    chk("rstmid_level", FIFO_LEVEL, 0);
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_ready", SYM_READY, 1);
    chk("rstmid_state", int'(DBG_STATE), int'(IDLE));
    #2;
    RST_N = 1'b1;
    hi = 0;
    busy_cnt = 0;
    repeat (40) begin
      tick();
      hi += KEY_OUT;
      busy_cnt += BUSY;
    end
    chk("rstmid_no_play", hi, 0);
    chk("rstmid_no_busy", busy_cnt, 0);

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
Transmit side of the morse symbol interface. Accepts 2-bit morse symbols (dot, dash, letter gap, word gap) through a valid/ready handshake and buffers them in a small FIFO. Plays them out as a timed on/off key signal (LED/buzzer drive) using standard unit ratios. Symbol encoding is bit-compatible with the parser's DATA_OUT, so parser output can be looped back for echo.

Parameters:
UNIT_CYCLES, 12_500_000, CLK cycles per morse time unit (>=2)
DEPTH, 8, symbol FIFO depth (power of 2, >=2)

Ports:
CLK  input  1  system clock; all logic on posedge
RST_N  input  1  asynchronous active-low reset
EN  input  1  playback enable; low pauses playback (FIFO still accepts)
SYM_VALID  input  1  symbol offered this cycle
SYM_DATA  input  2  00 letter gap, 01 dot, 10 dash, 11 word gap
SYM_READY  output  1  FIFO can accept; equals !full
KEY_OUT  output  1  registered key signal, 1 = mark (tone/LED on)
BUSY  output  1  state != IDLE or FIFO non-empty
FIFO_LEVEL  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- One clock (CLK); reset is asynchronous, active-low (RST_N). During/after reset: KEY_OUT=0, BUSY=0, SYM_READY=1, FIFO_LEVEL=0, state IDLE, prescaler and unit counter 0, FIFO emptied.
- Push when SYM_VALID && SYM_READY; SYM_READY = !full, independent of pop in the same cycle (no push at full even if popping). Pop and push in the same cycle on a non-full, non-empty FIFO: level unchanged.
- Prescaler counts 0..UNIT_CYCLES-1 and emits a unit tick on the terminal count. It reloads to 0 on every state entry, so each segment is exactly N*UNIT_CYCLES cycles.
- States: IDLE, MARK, SPACE.
- IDLE: if EN && !empty, pop and load the segment in one cycle:
  - dot: MARK, 1 unit
  - dash: MARK, 3 units
  - letter gap: SPACE, 2 units
  - word gap: SPACE, 6 units
- MARK: KEY_OUT=1. After the loaded units, go to SPACE for 1 unit (inter-element gap).
- SPACE: KEY_OUT=0. On the final cycle: if EN && !empty, pop and enter the next segment directly (no IDLE bubble); else go to IDLE.
- Resulting off-times: dot/dash followed by letter gap gives 3 units off; followed by word gap gives 7 units off.
- Latency: pop cycle N; KEY_OUT reflects the new segment at cycle N+1 (registered output).
- EN low: state, prescaler and unit counter freeze; KEY_OUT forced 0; no pops. On EN high, timing resumes from the frozen count. The remaining mark time is not restarted.
- Pushes are allowed in any state and while EN=0.
- Reset mid-symbol: immediate return to reset values; buffered symbols are discarded.
- FIFO pointers wrap modulo DEPTH; level saturates by construction at DEPTH (push blocked).

Decomposition:
- Package morse_pkg:
  - sym_t enum: SYM_GAP=2'b00, SYM_DOT=2'b01, SYM_DASH=2'b10, SYM_WORD=2'b11
  - state_t enum: IDLE, MARK, SPACE
  - unit-count constants: DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LETTER_EXTRA_UNITS=2, WORD_EXTRA_UNITS=6
  - Shared with morse_parser for symbol encoding.
- Sub-module sym_fifo (params WIDTH=2, DEPTH): sync FIFO with full/empty/level, async active-low reset. Keyer holds the FSM, prescaler and unit counter.

Test Plan (UNIT_CYCLES=4, DEPTH=8):
- Reset then push one dot with EN=1 -> pop next cycle; KEY_OUT high exactly 4 cycles, then low 4 cycles; then IDLE, BUSY=0.
- Push dash, letter gap, dot back-to-back -> KEY_OUT high 12, low 12 (4+8), high 4, low 4; no extra bubble cycles between segments.
- EN=0, push 9 symbols -> SYM_READY drops after 8th accept, FIFO_LEVEL=8, 9th held by source; KEY_OUT stays 0; raise EN -> playback starts, SYM_READY returns high after first pop.
- Dash playing, drop EN for 10 cycles after 5 mark cycles -> KEY_OUT 0 during pause, then 7 more high cycles after EN returns (total 12 mark cycles).
- Push word gap alone -> KEY_OUT stays 0 for 24 cycles, BUSY=1 throughout, then BUSY=0.
- Assert RST_N low mid-dash with 3 symbols queued -> KEY_OUT=0 and FIFO_LEVEL=0 immediately (asynchronous); after release, nothing plays.
